// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline.
// Holds ALU opcode encodings, control-word bit positions, condition-code
// register bit positions, the default multiplier iteration count and the
// multiplier FSM state type.
package pipeline_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_DEC  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_SETC = 4'd12;
  localparam logic [3:0] OP_CLRC = 4'd13;

  // Control word layout: [3:0] alu_op, then single-bit flags.
  localparam int CTRL_USE_IMM  = 4;
  localparam int CTRL_FLAGS_WE = 5;
  localparam int CTRL_JZ       = 6;
  localparam int CTRL_JMP      = 7;
  localparam int CTRL_VALID    = 8;

  // CCR is presented as {C, N, Z}.
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;

  localparam int MUL_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_t;

endpackage

// File: rtl/iterative_multiplier.sv
// Iterative 16x16 shift-add multiplier.
// Ports: clk, reset (async, active-high), start (accepted in IDLE only),
// abort (drops BUSY/DONE back to IDLE), a/b operands latched on start,
// busy (high for MUL_CYCLES cycles), done (one-cycle pulse), product[31:0]
// (valid while done is high).
module iterative_multiplier
  import pipeline_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      mcand;
  logic [15:0]      mplier;

  // Control: state, counter and registered busy/done flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MUL_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            state <= MUL_BUSY;
            count <= CNT_LOAD;
            busy  <= 1'b1;
          end
        end
        MUL_BUSY: begin
          if (abort) begin
            state <= MUL_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (count == '0) begin
            state <= MUL_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        MUL_DONE: begin
          state <= MUL_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= MUL_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: one conditional add of the shifted multiplicand per BUSY cycle.
  always_ff @(posedge clk) begin
    if (state == MUL_IDLE && start) begin
      mcand   <= {16'b0, a};
      mplier  <= b;
      product <= '0;
    end else if (state == MUL_BUSY) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit five-stage pipeline.
// Inputs: control word, register numbers/values and immediate from the DE
// register, EM/MW forwarding buses, flush_IN. Outputs: ALU result, CCR
// {C,N,Z}, stall toward PC/FD/DE, branch redirect, valid and pass-through
// destination/control toward the EM register. Every output reads 0 while
// reset is held.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int NUMBER_CONTROL_SIGNALS = 16,
  parameter int MUL_CYCLES             = MUL_CYCLES_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMBER_CONTROL_SIGNALS-1:0] control_sinals_IN,
  input  logic [3:0]                        reg_dst_num_IN,
  input  logic [2:0]                        reg_src_1_num_IN,
  input  logic [15:0]                       reg_src_1_value_IN,
  input  logic [3:0]                        reg_src_2_num_IN,
  input  logic [15:0]                       reg_src_2_value_IN,
  input  logic [15:0]                       address_IN,
  input  logic                              em_fwd_en,
  input  logic [3:0]                        em_fwd_num,
  input  logic [15:0]                       em_fwd_value,
  input  logic                              mw_fwd_en,
  input  logic [3:0]                        mw_fwd_num,
  input  logic [15:0]                       mw_fwd_value,
  input  logic                              flush_IN,
  output logic [15:0]                       alu_result_OUT,
  output logic [2:0]                        flags_OUT,
  output logic                              stall_OUT,
  output logic                              branch_taken_OUT,
  output logic [15:0]                       branch_target_OUT,
  output logic                              valid_OUT,
  output logic [3:0]                        reg_dst_num_OUT,
  output logic [NUMBER_CONTROL_SIGNALS-1:0] control_sinals_OUT
);

  function automatic logic shl_carry(input logic [15:0] a, input logic [3:0] n);
    return |(({16'b0, a} << n) & 32'h0001_0000);
  endfunction

  function automatic logic shr_carry(input logic [15:0] a, input logic [3:0] n);
    return |(({a, 16'b0} >> n) & 32'h0000_8000);
  endfunction

  logic [3:0]  alu_op;
  logic        valid, use_imm, flags_we, jz, jmp;
  logic [15:0] op_a, fwd_b, op_b;
  logic [3:0]  shamt;
  logic        mul_start, mul_busy, mul_done;
  logic [31:0] mul_product;
  logic        stall, flag_wr;
  logic [15:0] res;
  logic        c_next, zn_we;
  logic [2:0]  ccr;

  assign alu_op   = control_sinals_IN[3:0];
  assign use_imm  = control_sinals_IN[CTRL_USE_IMM];
  assign flags_we = control_sinals_IN[CTRL_FLAGS_WE];
  assign jz       = control_sinals_IN[CTRL_JZ];
  assign jmp      = control_sinals_IN[CTRL_JMP];
  assign valid    = control_sinals_IN[CTRL_VALID];

  // Operand select: EM beats MW beats register file. Source 1 is a 3-bit
  // number, so it can never match a forward to registers 8..15.
  always_comb begin
    op_a = reg_src_1_value_IN;
    if (em_fwd_en && em_fwd_num == {1'b0, reg_src_1_num_IN})      op_a = em_fwd_value;
    else if (mw_fwd_en && mw_fwd_num == {1'b0, reg_src_1_num_IN}) op_a = mw_fwd_value;

    fwd_b = reg_src_2_value_IN;
    if (em_fwd_en && em_fwd_num == reg_src_2_num_IN)      fwd_b = em_fwd_value;
    else if (mw_fwd_en && mw_fwd_num == reg_src_2_num_IN) fwd_b = mw_fwd_value;
  end

  assign op_b  = use_imm ? address_IN : fwd_b;
  assign shamt = op_b[3:0];

  // A MUL is only accepted from IDLE; the DE register holds it in place
  // for the whole iteration, so BUSY/DONE must not re-trigger it.
  assign mul_start = valid && (alu_op == OP_MUL) && !flush_IN && !mul_busy && !mul_done;
  assign stall     = mul_start || mul_busy;

  iterative_multiplier #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (flush_IN),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    res    = '0;
    c_next = ccr[CCR_C];
    zn_we  = 1'b1;
    case (alu_op)
      OP_MOV:  res = op_b;
      OP_ADD:  {c_next, res} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  begin res = op_a - op_b; c_next = (op_a < op_b); end
      OP_AND:  res = op_a & op_b;
      OP_OR:   res = op_a | op_b;
      OP_NOT:  res = ~op_a;
      OP_INC:  res = op_a + 16'd1;
      OP_DEC:  res = op_a - 16'd1;
      OP_SHL:  begin
        res = op_a << shamt;
        if (shamt != 4'd0) c_next = shl_carry(op_a, shamt);
      end
      OP_SHR:  begin
        res = op_a >> shamt;
        if (shamt != 4'd0) c_next = shr_carry(op_a, shamt);
      end
      OP_SETC: begin c_next = 1'b1; zn_we = 1'b0; end
      OP_CLRC: begin c_next = 1'b0; zn_we = 1'b0; end
      default: res = '0;
    endcase
    // In DONE the held MUL instruction reports the product instead.
    if (mul_done) begin
      res    = mul_product[15:0];
      c_next = |mul_product[31:16];
      zn_we  = 1'b1;
    end
  end

  assign flag_wr = valid && flags_we && !stall && !flush_IN;

  // CCR register boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ccr <= 3'b000;
    end else if (flag_wr) begin
      if (zn_we) begin
        ccr[CCR_Z] <= (res == 16'h0000);
        ccr[CCR_N] <= res[15];
      end
      ccr[CCR_C] <= c_next;
    end
  end

  assign alu_result_OUT     = reset ? 16'h0000 : res;
  assign flags_OUT          = reset ? 3'b000 : ccr;
  assign stall_OUT          = !reset && stall;
  assign valid_OUT          = !reset && !flush_IN && ((valid && !stall) || mul_done);
  assign branch_taken_OUT   = !reset && valid && (jmp || (jz && ccr[CCR_Z])) && !flush_IN;
  assign branch_target_OUT  = reset ? 16'h0000 : op_a;
  assign reg_dst_num_OUT    = reset ? 4'h0 : reg_dst_num_IN;
  assign control_sinals_OUT = (reset || stall || flush_IN) ? '0 : control_sinals_IN;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] control_sinals_IN;
  logic [3:0]  reg_dst_num_IN;
  logic [2:0]  reg_src_1_num_IN;
  logic [15:0] reg_src_1_value_IN;
  logic [3:0]  reg_src_2_num_IN;
  logic [15:0] reg_src_2_value_IN;
  logic [15:0] address_IN;
  logic        em_fwd_en;
  logic [3:0]  em_fwd_num;
  logic [15:0] em_fwd_value;
  logic        mw_fwd_en;
  logic [3:0]  mw_fwd_num;
  logic [15:0] mw_fwd_value;
  logic        flush_IN;
  logic [15:0] alu_result_OUT;
  logic [2:0]  flags_OUT;
  logic        stall_OUT;
  logic        branch_taken_OUT;
  logic [15:0] branch_target_OUT;
  logic        valid_OUT;
  logic [3:0]  reg_dst_num_OUT;
  logic [15:0] control_sinals_OUT;

  always #5 clk = ~clk;

  execute_stage #(
    .NUMBER_CONTROL_SIGNALS(16),
    .MUL_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .control_sinals_IN(control_sinals_IN), .reg_dst_num_IN(reg_dst_num_IN),
    .reg_src_1_num_IN(reg_src_1_num_IN), .reg_src_1_value_IN(reg_src_1_value_IN),
    .reg_src_2_num_IN(reg_src_2_num_IN), .reg_src_2_value_IN(reg_src_2_value_IN),
    .address_IN(address_IN),
    .em_fwd_en(em_fwd_en), .em_fwd_num(em_fwd_num), .em_fwd_value(em_fwd_value),
    .mw_fwd_en(mw_fwd_en), .mw_fwd_num(mw_fwd_num), .mw_fwd_value(mw_fwd_value),
    .flush_IN(flush_IN),
    .alu_result_OUT(alu_result_OUT), .flags_OUT(flags_OUT), .stall_OUT(stall_OUT),
    .branch_taken_OUT(branch_taken_OUT), .branch_target_OUT(branch_target_OUT),
    .valid_OUT(valid_OUT), .reg_dst_num_OUT(reg_dst_num_OUT),
    .control_sinals_OUT(control_sinals_OUT)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic em_en, mw_en;
    logic [3:0] em_n, mw_n;
    logic [15:0] ctrl;
    logic [2:0] s1n;
    logic [15:0] s1v;
    logic [3:0] s2n;
    logic [15:0] s2v, addr, res;
  } fwd_case_t;

  typedef struct {
    logic [15:0] ctrl, a, b, addr, res;
    logic [2:0] fl;
  } alu_case_t;

  function automatic logic [15:0] ctl(input logic [3:0] op, input logic imm,
                                      input logic fwe, input logic jz, input logic jmp);
    return {7'b0, 1'b1, jmp, jz, fwe, imm, op};
  endfunction

  task automatic drive(input logic [15:0] ctrl, input logic [3:0] dst,
                       input logic [2:0] s1n, input logic [15:0] s1v,
                       input logic [3:0] s2n, input logic [15:0] s2v,
                       input logic [15:0] addr);
    @(posedge clk);
    #1;
    control_sinals_IN  = ctrl;
    reg_dst_num_IN     = dst;
    reg_src_1_num_IN   = s1n;
    reg_src_1_value_IN = s1v;
    reg_src_2_num_IN   = s2n;
    reg_src_2_value_IN = s2v;
    address_IN         = addr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush_IN = 1'b0;
    em_fwd_en = 1'b1; em_fwd_num = 4'd1; em_fwd_value = 16'h0AAA;
    mw_fwd_en = 1'b0; mw_fwd_num = 4'd0; mw_fwd_value = 16'h0000;
    control_sinals_IN = ctl(OP_ADD, 1'b0, 1'b1, 1'b0, 1'b1);
    reg_dst_num_IN = 4'd9;
    reg_src_1_num_IN = 3'd1; reg_src_1_value_IN = 16'h0011;
    reg_src_2_num_IN = 4'd2; reg_src_2_value_IN = 16'h0022;
    address_IN = 16'h0033;
    repeat (2) @(negedge clk);
    checks++; if (alu_result_OUT !== 16'h0) begin errors++; $display("FAIL reset_result got=%h exp=0000", alu_result_OUT); end
    checks++; if (flags_OUT !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", flags_OUT); end
    checks++; if (stall_OUT !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_OUT); end
    checks++; if (valid_OUT !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_OUT); end
    checks++; if (branch_taken_OUT !== 1'b0) begin errors++; $display("FAIL reset_branch got=%b exp=0", branch_taken_OUT); end
    checks++; if (branch_target_OUT !== 16'h0) begin errors++; $display("FAIL reset_target got=%h exp=0000", branch_target_OUT); end
    checks++; if (reg_dst_num_OUT !== 4'h0) begin errors++; $display("FAIL reset_dst got=%h exp=0", reg_dst_num_OUT); end
    checks++; if (control_sinals_OUT !== 16'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0000", control_sinals_OUT); end
    control_sinals_IN = 16'h0;
    em_fwd_en = 1'b0;
    #2 reset = 1'b0;
  endtask

  task automatic test_forwarding();
    fwd_case_t cs[$];
    logic [15:0] exp;
    em_fwd_value = 16'd7;
    mw_fwd_value = 16'd9;
    cs.push_back('{1'b1, 1'b1, 4'd2, 4'd2, ctl(OP_ADD,0,0,0,0), 3'd2, 16'd5, 4'd3, 16'd3, 16'h0, 16'd10});
    cs.push_back('{1'b0, 1'b1, 4'd2, 4'd2, ctl(OP_ADD,0,0,0,0), 3'd2, 16'd5, 4'd3, 16'd3, 16'h0, 16'd12});
    cs.push_back('{1'b0, 1'b0, 4'd2, 4'd2, ctl(OP_ADD,0,0,0,0), 3'd2, 16'd5, 4'd3, 16'd3, 16'h0, 16'd8});
    cs.push_back('{1'b1, 1'b1, 4'd2, 4'd2, ctl(OP_MOV,0,0,0,0), 3'd2, 16'd5, 4'd2, 16'd3, 16'h0, 16'd7});
    cs.push_back('{1'b0, 1'b1, 4'd2, 4'd2, ctl(OP_MOV,0,0,0,0), 3'd2, 16'd5, 4'd2, 16'd3, 16'h0, 16'd9});
    cs.push_back('{1'b1, 1'b1, 4'd2, 4'd2, ctl(OP_MOV,1,0,0,0), 3'd2, 16'd5, 4'd2, 16'd3, 16'h1234, 16'h1234});
    cs.push_back('{1'b1, 1'b1, 4'hA, 4'hA, ctl(OP_ADD,0,0,0,0), 3'd2, 16'd5, 4'hA, 16'd3, 16'h0, 16'd12});
    foreach (cs[i]) begin
      drive(cs[i].ctrl, 4'd6, cs[i].s1n, cs[i].s1v, cs[i].s2n, cs[i].s2v, cs[i].addr);
      em_fwd_en = cs[i].em_en; em_fwd_num = cs[i].em_n;
      mw_fwd_en = cs[i].mw_en; mw_fwd_num = cs[i].mw_n;
      exp_q.push_back(cs[i].res);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (valid_OUT !== 1'b1) begin errors++; $display("FAIL fwd%0d_valid got=%b exp=1", i, valid_OUT); end
      checks++; if (alu_result_OUT !== exp) begin errors++; $display("FAIL fwd%0d_result got=%h exp=%h", i, alu_result_OUT, exp); end
      checks++; if (reg_dst_num_OUT !== 4'd6) begin errors++; $display("FAIL fwd%0d_dst got=%h exp=6", i, reg_dst_num_OUT); end
      checks++; if (control_sinals_OUT !== cs[i].ctrl) begin errors++; $display("FAIL fwd%0d_ctrl got=%h exp=%h", i, control_sinals_OUT, cs[i].ctrl); end
    end
    em_fwd_en = 1'b0; mw_fwd_en = 1'b0;
  endtask

  task automatic test_alu();
    alu_case_t cs[$];
    logic [15:0] exp;
    cs.push_back('{ctl(OP_SUB,0,1,0,0),  16'h0003, 16'h0005, 16'h0, 16'hFFFE, 3'b110});
    cs.push_back('{ctl(OP_ADD,0,1,0,0),  16'hFFFF, 16'h0001, 16'h0, 16'h0000, 3'b101});
    cs.push_back('{ctl(OP_AND,0,1,0,0),  16'hF0F0, 16'h0FF0, 16'h0, 16'h00F0, 3'b100});
    cs.push_back('{ctl(OP_CLRC,0,1,0,0), 16'h0000, 16'h0000, 16'h0, 16'h0000, 3'b000});
    cs.push_back('{ctl(OP_SHL,0,1,0,0),  16'h8001, 16'h0001, 16'h0, 16'h0002, 3'b100});
    cs.push_back('{ctl(OP_SHR,0,1,0,0),  16'h0005, 16'h0002, 16'h0, 16'h0001, 3'b000});
    cs.push_back('{ctl(OP_SETC,0,1,0,0), 16'h0000, 16'h0000, 16'h0, 16'h0000, 3'b100});
    cs.push_back('{ctl(OP_SHR,0,1,0,0),  16'h0004, 16'h0000, 16'h0, 16'h0004, 3'b100});
    cs.push_back('{ctl(OP_NOT,0,1,0,0),  16'h00FF, 16'h0000, 16'h0, 16'hFF00, 3'b110});
    cs.push_back('{ctl(OP_INC,0,1,0,0),  16'hFFFF, 16'h0000, 16'h0, 16'h0000, 3'b101});
    cs.push_back('{ctl(OP_DEC,0,1,0,0),  16'h0000, 16'h0000, 16'h0, 16'hFFFF, 3'b110});
    cs.push_back('{ctl(OP_OR,1,1,0,0),   16'h1200, 16'hFFFF, 16'h0034, 16'h1234, 3'b100});
    cs.push_back('{ctl(OP_MOV,0,0,0,0),  16'h0000, 16'h5555, 16'h0, 16'h5555, 3'b100});
    foreach (cs[i]) begin
      drive(cs[i].ctrl, 4'd3, 3'd1, cs[i].a, 4'd2, cs[i].b, cs[i].addr);
      exp_q.push_back(cs[i].res);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (alu_result_OUT !== exp) begin errors++; $display("FAIL alu%0d_result got=%h exp=%h", i, alu_result_OUT, exp); end
      drive(16'h0, 4'd0, 3'd0, 16'h0, 4'd0, 16'h0, 16'h0);
      @(negedge clk);
      checks++; if (flags_OUT !== cs[i].fl) begin errors++; $display("FAIL alu%0d_flags got=%b exp=%b", i, flags_OUT, cs[i].fl); end
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp;
    em_fwd_en = 1'b0;
    mw_fwd_en = 1'b1; mw_fwd_num = 4'd3; mw_fwd_value = 16'h0040;
    drive(ctl(OP_SUB,0,1,0,0), 4'd1, 3'd1, 16'd4, 4'd2, 16'd4, 16'h0);
    exp_q.push_back(16'h0000);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (alu_result_OUT !== exp) begin errors++; $display("FAIL br_sub_result got=%h exp=%h", alu_result_OUT, exp); end
    drive(ctl(OP_NOP,0,0,1,0), 4'd0, 3'd3, 16'h1111, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (flags_OUT !== 3'b001) begin errors++; $display("FAIL br_zflag got=%b exp=001", flags_OUT); end
    checks++; if (branch_taken_OUT !== 1'b1) begin errors++; $display("FAIL br_jz_taken got=%b exp=1", branch_taken_OUT); end
    checks++; if (branch_target_OUT !== 16'h0040) begin errors++; $display("FAIL br_jz_target got=%h exp=0040", branch_target_OUT); end
    drive(ctl(OP_ADD,0,1,0,0), 4'd1, 3'd1, 16'd1, 4'd2, 16'd1, 16'h0);
    exp_q.push_back(16'h0002);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (alu_result_OUT !== exp) begin errors++; $display("FAIL br_add_result got=%h exp=%h", alu_result_OUT, exp); end
    drive(ctl(OP_NOP,0,0,1,0), 4'd0, 3'd3, 16'h1111, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (branch_taken_OUT !== 1'b0) begin errors++; $display("FAIL br_jz_nottaken got=%b exp=0", branch_taken_OUT); end
    drive(ctl(OP_NOP,0,0,0,1), 4'd0, 3'd3, 16'h1111, 4'd0, 16'h0, 16'h0);
    flush_IN = 1'b1;
    @(negedge clk);
    checks++; if (branch_taken_OUT !== 1'b0) begin errors++; $display("FAIL br_jmp_flushed got=%b exp=0", branch_taken_OUT); end
    checks++; if (valid_OUT !== 1'b0) begin errors++; $display("FAIL br_flush_valid got=%b exp=0", valid_OUT); end
    drive(ctl(OP_NOP,0,0,0,1), 4'd0, 3'd3, 16'h1111, 4'd0, 16'h0, 16'h0);
    flush_IN = 1'b0;
    @(negedge clk);
    checks++; if (branch_taken_OUT !== 1'b1) begin errors++; $display("FAIL br_jmp_taken got=%b exp=1", branch_taken_OUT); end
    checks++; if (branch_target_OUT !== 16'h0040) begin errors++; $display("FAIL br_jmp_target got=%h exp=0040", branch_target_OUT); end
    mw_fwd_en = 1'b0;
    drive(16'h0, 4'd0, 3'd0, 16'h0, 4'd0, 16'h0, 16'h0);
  endtask

  task automatic test_multiply();
    int stalls;
    logic got;
    logic [15:0] exp;
    drive(ctl(OP_MUL,0,1,0,0), 4'd4, 3'd1, 16'h0102, 4'd2, 16'h0100, 16'h0);
    exp_q.push_back(16'h0200);
    stalls = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (control_sinals_OUT !== 16'h0) begin errors++; $display("FAIL mul_ctrl_stalled got=%h exp=0000", control_sinals_OUT); end
      end
      if (valid_OUT === 1'b1) got = 1'b1;
      else if (stall_OUT === 1'b1) stalls++;
    end
    exp = exp_q.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mul_done_seen got=%b exp=1", got); end
    checks++; if (stalls != 17) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=17", stalls); end
    checks++; if (stall_OUT !== 1'b0) begin errors++; $display("FAIL mul_done_stall got=%b exp=0", stall_OUT); end
    checks++; if (alu_result_OUT !== exp) begin errors++; $display("FAIL mul_result got=%h exp=%h", alu_result_OUT, exp); end
    // Back-to-back: an ADD directly behind the finished MUL.
    drive(ctl(OP_ADD,0,0,0,0), 4'd5, 3'd1, 16'h0001, 4'd2, 16'h0002, 16'h0);
    exp_q.push_back(16'h0003);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (alu_result_OUT !== exp) begin errors++; $display("FAIL b2b_result got=%h exp=%h", alu_result_OUT, exp); end
    checks++; if (flags_OUT !== 3'b100) begin errors++; $display("FAIL mul_flags got=%b exp=100", flags_OUT); end
    drive(16'h0, 4'd0, 3'd0, 16'h0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (valid_OUT !== 1'b0) begin errors++; $display("FAIL mul_idle_valid got=%b exp=0", valid_OUT); end
  endtask

  task automatic test_flush();
    int pulses;
    drive(ctl(OP_MUL,0,1,0,0), 4'd4, 3'd1, 16'h0000, 4'd2, 16'h0005, 16'h0);
    @(negedge clk);
    checks++; if (stall_OUT !== 1'b1) begin errors++; $display("FAIL fl_accept_stall got=%b exp=1", stall_OUT); end
    repeat (5) @(posedge clk);
    #1 flush_IN = 1'b1;
    @(negedge clk);
    checks++; if (valid_OUT !== 1'b0) begin errors++; $display("FAIL fl_flush_valid got=%b exp=0", valid_OUT); end
    @(posedge clk);
    #1;
    flush_IN = 1'b0;
    control_sinals_IN = 16'h0;
    @(negedge clk);
    checks++; if (stall_OUT !== 1'b0) begin errors++; $display("FAIL fl_stall_drop got=%b exp=0", stall_OUT); end
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid_OUT !== 1'b0 || stall_OUT !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL fl_no_activity got=%0d exp=0", pulses); end
    checks++; if (flags_OUT !== 3'b100) begin errors++; $display("FAIL fl_ccr_kept got=%b exp=100", flags_OUT); end
  endtask

  task automatic test_reset_mid();
    int stalls;
    logic got;
    logic [15:0] exp;
    drive(ctl(OP_MUL,0,1,0,0), 4'd4, 3'd1, 16'hFFFF, 4'd2, 16'hFFFF, 16'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    control_sinals_IN = 16'h0;
    #1;
    checks++; if (stall_OUT !== 1'b0) begin errors++; $display("FAIL rm_stall got=%b exp=0", stall_OUT); end
    checks++; if (valid_OUT !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", valid_OUT); end
    checks++; if (flags_OUT !== 3'b000) begin errors++; $display("FAIL rm_flags got=%b exp=000", flags_OUT); end
    @(posedge clk);
    #2 reset = 1'b0;
    drive(ctl(OP_MUL,0,1,0,0), 4'd4, 3'd1, 16'hFFFF, 4'd2, 16'hFFFF, 16'h0);
    exp_q.push_back(16'h0001);
    stalls = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (valid_OUT === 1'b1) got = 1'b1;
      else if (stall_OUT === 1'b1) stalls++;
    end
    exp = exp_q.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rm_mul_done got=%b exp=1", got); end
    checks++; if (stalls != 17) begin errors++; $display("FAIL rm_stall_cycles got=%0d exp=17", stalls); end
    checks++; if (alu_result_OUT !== exp) begin errors++; $display("FAIL rm_mul_result got=%h exp=%h", alu_result_OUT, exp); end
    drive(16'h0, 4'd0, 3'd0, 16'h0, 4'd0, 16'h0, 16'h0);
    @(negedge clk);
    checks++; if (flags_OUT !== 3'b100) begin errors++; $display("FAIL rm_mul_flags got=%b exp=100", flags_OUT); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_alu();
    test_branch();
    test_multiply();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
